// File: rtl/button_event_handler.sv
// Synchronizes, normalizes and debounces every pad, emitting one-cycle press/release pulses.
// Press/release outputs appear DEBOUNCE_CYCLES+2 edges after the first raw sampling edge; no backpressure.
module button_event_handler #(
  parameter int NUM_BTN         = 16,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] event_pulse,
  output logic [NUM_BTN-1:0] btn_held,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [4:0]         last_idx,
  output logic               any_press
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DB_PRESS = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_DB_REL   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] w_norm;
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_fall;
  logic [4:0]         w_first_idx;

  logic [NUM_BTN-1:0] r_event_pulse;
  logic [NUM_BTN-1:0] r_release_pulse;
  logic [NUM_BTN-1:0] r_btn_held;
  logic [4:0]         r_last_idx;
  logic               r_any_press;

  assign w_norm = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Reset value 0 is the normalized "released" level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_norm;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_pad
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_sync2[gi]) begin
              r_state <= ST_DB_PRESS;
              r_cnt   <= CNT_ONE;
            end
          end
          ST_DB_PRESS: begin
            if (!r_sync2[gi]) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= ST_HELD;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_HELD: begin
            if (!r_sync2[gi]) begin
              r_state <= ST_DB_REL;
              r_cnt   <= CNT_ONE;
            end
          end
          ST_DB_REL: begin
            if (r_sync2[gi]) begin
              r_state <= ST_HELD;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    // A bounce back during release debounce keeps the pad logically pressed.
    assign w_level[gi] = (r_state == ST_HELD) || (r_state == ST_DB_REL);
  end

  // Edges of the debounced level against the registered copy give single-cycle pulses.
  assign w_rise = w_level & ~r_btn_held;
  assign w_fall = ~w_level & r_btn_held;

  always_comb begin
    w_first_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_rise[i]) w_first_idx = 5'(i);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_event_pulse   <= '0;
      r_release_pulse <= '0;
      r_btn_held      <= '0;
      r_last_idx      <= '0;
      r_any_press     <= 1'b0;
    end else begin
      r_event_pulse   <= w_rise;
      r_release_pulse <= w_fall;
      r_btn_held      <= w_level;
      r_any_press     <= |w_rise;
      if (|w_rise) r_last_idx <= w_first_idx;
    end
  end

  assign event_pulse   = r_event_pulse;
  assign release_pulse = r_release_pulse;
  assign btn_held      = r_btn_held;
  assign last_idx      = r_last_idx;
  assign any_press     = r_any_press;

endmodule

// File: tb/tb_button_event_handler.sv
// Bench for button_event_handler: directed table, corner sequences and random stimulus vs a run-length model.
module tb_button_event_handler;
  localparam int NB = 16;
  localparam int DB = 4;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] event_pulse;
  logic [NB-1:0] btn_held;
  logic [NB-1:0] release_pulse;
  logic [4:0]    last_idx;
  logic          any_press;

  int total = 0;
  int bad   = 0;

  button_event_handler #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .CNT_W(CW), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .btn_raw(btn_raw), .event_pulse(event_pulse),
    .btn_held(btn_held), .release_pulse(release_pulse), .last_idx(last_idx),
    .any_press(any_press)
  );

  always #5 CLK = ~CLK;

  // Reference: a pad flips its debounced level after DB consecutive raw samples
  // disagreeing with it; results surface three edges later (two sync flops + output).
  typedef struct packed {
    logic [NB-1:0] evt;
    logic [NB-1:0] rel;
    logic [NB-1:0] held;
    logic [4:0]    last;
    logic          any;
  } out_t;

  int            m_run [NB];
  logic [NB-1:0] m_lvl;
  logic [4:0]    m_last;
  out_t          m_pipe [$];
  out_t          m_exp;

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] evt;
    logic [NB-1:0] rel;
    logic [NB-1:0] held;
    logic [4:0]    last;
    logic          any;
  } vec_t;

  vec_t          tbl [18];
  int            first;
  int            n_evt;
  logic [NB-1:0] r;
  logic [NB-1:0] p;
  logic [NB-1:0] evt_seen;
  logic [4:0]    last_seen;
  logic [31:0]   rnd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    m_lvl  = '0;
    m_last = '0;
    m_pipe.delete();
    for (int i = 0; i < 3; i++) m_pipe.push_back('0);
  endtask

  task automatic model_step(input logic [NB-1:0] raw);
    logic [NB-1:0] pressed;
    logic [NB-1:0] evt;
    logic [NB-1:0] rel;
    out_t          rec;
    pressed = ~raw;
    evt     = '0;
    rel     = '0;
    for (int i = 0; i < NB; i++) begin
      if (pressed[i] != m_lvl[i]) m_run[i] = m_run[i] + 1;
      else m_run[i] = 0;
      if (m_run[i] == DB) begin
        m_run[i] = 0;
        m_lvl[i] = pressed[i];
        if (pressed[i]) evt[i] = 1'b1;
        else rel[i] = 1'b1;
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (evt[i]) begin
        m_last = 5'(i);
        break;
      end
    end
    rec.evt  = evt;
    rec.rel  = rel;
    rec.held = m_lvl;
    rec.last = m_last;
    rec.any  = |evt;
    m_pipe.push_back(rec);
    m_exp = m_pipe.pop_front();
  endtask

  task automatic step(input logic [NB-1:0] raw);
    btn_raw = raw;
    @(posedge CLK);
    model_step(raw);
    #1;
    chk("model_event_pulse", 32'(event_pulse), 32'(m_exp.evt));
    chk("model_release_pulse", 32'(release_pulse), 32'(m_exp.rel));
    chk("model_btn_held", 32'(btn_held), 32'(m_exp.held));
    chk("model_last_idx", 32'(last_idx), 32'(m_exp.last));
    chk("model_any_press", 32'(any_press), 32'(m_exp.any));
  endtask

  task automatic pulse_reset(input logic [NB-1:0] raw);
    btn_raw = raw;
    RST = 1'b0;
    #2;
    chk("rst_event_pulse", 32'(event_pulse), 32'd0);
    chk("rst_release_pulse", 32'(release_pulse), 32'd0);
    chk("rst_btn_held", 32'(btn_held), 32'd0);
    chk("rst_last_idx", 32'(last_idx), 32'd0);
    chk("rst_any_press", 32'(any_press), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    model_reset();
  endtask

  initial begin
    // Clean press of pad 3 (raw active low) then release; outputs land 6 edges after each change.
    for (int j = 0; j < 18; j++) begin
      tbl[j].raw  = (j < 10) ? 16'hFFF7 : 16'hFFFF;
      tbl[j].evt  = (j == 6) ? 16'h0008 : 16'h0000;
      tbl[j].rel  = (j == 16) ? 16'h0008 : 16'h0000;
      tbl[j].held = (j >= 6 && j < 16) ? 16'h0008 : 16'h0000;
      tbl[j].last = (j >= 6) ? 5'd3 : 5'd0;
      tbl[j].any  = (j == 6);
    end

    RST     = 1'b1;
    btn_raw = '1;
    #1;
    pulse_reset('1);
    for (int j = 0; j < 4; j++) step('1);

    for (int j = 0; j < 18; j++) begin
      step(tbl[j].raw);
      chk("tbl_event_pulse", 32'(event_pulse), 32'(tbl[j].evt));
      chk("tbl_release_pulse", 32'(release_pulse), 32'(tbl[j].rel));
      chk("tbl_btn_held", 32'(btn_held), 32'(tbl[j].held));
      chk("tbl_last_idx", 32'(last_idx), 32'(tbl[j].last));
      chk("tbl_any_press", 32'(any_press), 32'(tbl[j].any));
    end
    for (int j = 0; j < 8; j++) step('1);

    // Bounce on pad 5: stable press begins at step 4, pulse expected after step 10.
    first = -1;
    n_evt = 0;
    for (int j = 0; j < 20; j++) begin
      r = '1;
      r[5] = (j < 4) ? j[0] : 1'b0;
      step(r);
      if (event_pulse[5]) begin
        n_evt++;
        if (first < 0) first = j;
      end
    end
    chk("bounce_first_step", 32'(first), 32'd10);
    chk("bounce_pulse_count", 32'(n_evt), 32'd1);
    for (int j = 0; j < 10; j++) step('1);

    // Simultaneous press of pads 9 and 2.
    first     = -1;
    n_evt     = 0;
    evt_seen  = '0;
    last_seen = '0;
    for (int j = 0; j < 12; j++) begin
      step(~16'h0204);
      if (event_pulse != '0) begin
        n_evt++;
        if (first < 0) begin
          first     = j;
          evt_seen  = event_pulse;
          last_seen = last_idx;
        end
      end
    end
    chk("simul_first_step", 32'(first), 32'd6);
    chk("simul_event_value", 32'(evt_seen), 32'h0204);
    chk("simul_last_idx", 32'(last_seen), 32'd2);
    chk("simul_pulse_cycles", 32'(n_evt), 32'd1);
    for (int j = 0; j < 10; j++) step('1);

    // Long hold on pad 0 must pulse exactly once.
    n_evt = 0;
    for (int j = 0; j < 1000; j++) begin
      step(~16'h0001);
      if (event_pulse[0]) n_evt++;
    end
    chk("hold_pulse_count", 32'(n_evt), 32'd1);
    chk("hold_btn_held", 32'(btn_held[0]), 32'd1);
    for (int j = 0; j < 10; j++) step('1);

    // Reset during pad-3 debounce while pad 7 is held; both restart as fresh presses.
    for (int j = 0; j < 8; j++) step(~16'h0080);
    for (int j = 0; j < 3; j++) step(~16'h0088);
    pulse_reset(~16'h0088);
    first     = -1;
    n_evt     = 0;
    evt_seen  = '0;
    last_seen = '0;
    for (int j = 0; j < 12; j++) begin
      step(~16'h0088);
      if (event_pulse[3]) begin
        n_evt++;
        if (first < 0) begin
          first     = j;
          evt_seen  = event_pulse;
          last_seen = last_idx;
        end
      end
    end
    chk("rst_mid_first_step", 32'(first), 32'd6);
    chk("rst_mid_event_value", 32'(evt_seen), 32'h0088);
    chk("rst_mid_last_idx", 32'(last_seen), 32'd3);
    chk("rst_mid_pulse_count", 32'(n_evt), 32'd1);
    for (int j = 0; j < 10; j++) step('1);

    // Random pad activity with sparse toggles so both bounces and clean presses occur.
    p = '0;
    for (int j = 0; j < 1500; j++) begin
      rnd = $urandom & $urandom & $urandom;
      p   = p ^ rnd[NB-1:0];
      if (j == 750) pulse_reset(~p);
      step(~p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
